// File: rtl/network_rx_write.sv
`default_nettype none
// ============================================================================
//  Module      : network_rx_write
//  Description : GMII receive path for one network interface. Strips the
//                preamble/SFD, packs frame bytes into 134-bit buffer words,
//                writes them at {bufid, line} using a prefetched buffer id,
//                and issues a {length, bufid} descriptor per good frame.
//                Optional macro NRX_CRC_CHECK_EN enables the Ethernet FCS
//                check; without it the FCS is stored unchecked.
//  Revision    : 1.0 - initial release
// ============================================================================
module network_rx_write (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [7:0]   iv_gmii_rxd,
    input  logic         i_gmii_rx_dv,
    input  logic         i_gmii_rx_er,
    input  logic [8:0]   iv_pkt_bufid,
    input  logic         i_pkt_bufid_wr,
    output logic         o_pkt_bufid_ack,
    output logic [133:0] ov_pkt_data,
    output logic         o_pkt_data_wr,
    output logic [15:0]  ov_pkt_waddr,
    output logic [20:0]  ov_pkt_descriptor,
    output logic         o_pkt_descriptor_wr,
    output logic         o_inpkt_pulse,
    output logic         o_discard_pulse,
    output logic [1:0]   ov_nrx_state
);

    localparam logic [1:0]  c_ST_IDLE     = 2'd0;
    localparam logic [1:0]  c_ST_PREAMBLE = 2'd1;
    localparam logic [1:0]  c_ST_DATA     = 2'd2;
    localparam logic [1:0]  c_ST_DISCARD  = 2'd3;

    localparam logic [7:0]  c_SFD         = 8'hD5;
    localparam logic [11:0] c_MIN_LEN     = 12'd64;
    localparam logic [11:0] c_MAX_LEN     = 12'd2048;

    localparam logic [1:0]  c_FLAG_FIRST  = 2'b01;
    localparam logic [1:0]  c_FLAG_MID    = 2'b11;
    localparam logic [1:0]  c_FLAG_LAST   = 2'b10;

    // Control and datapath state
    logic [1:0]   state_q,   state_d;
    logic         held_q,    held_d;
    logic [8:0]   bufid_q,   bufid_d;
    logic         ack_q,     ack_d;
    logic [11:0]  cnt_q,     cnt_d;
    logic [6:0]   line_q,    line_d;
    logic [127:0] word_q,    word_d;

    // Registered outputs
    logic [133:0] data_q,    data_d;
    logic         data_wr_q, data_wr_d;
    logic [15:0]  waddr_q,   waddr_d;
    logic [20:0]  desc_q,    desc_d;
    logic         desc_wr_q, desc_wr_d;
    logic         disc_q,    disc_d;

    // Bit offset of the byte slot being filled; slot 0 lands in [127:120]
    logic [6:0]   w_slot;
    // Unused trailing bytes in the final word: (16 - count mod 16) mod 16
    logic [3:0]   w_invalid;
    // High when the frame check sequence is acceptable (always, if unchecked)
    logic         w_crc_ok;

    assign w_slot    = {~cnt_q[3:0], 3'b000};
    assign w_invalid = 4'd0 - cnt_q[3:0];

`ifdef NRX_CRC_CHECK_EN
    // Residue of a correct frame, MSB-first form; the register runs reflected
    localparam logic [31:0] c_CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] c_CRC_POLY    = 32'hEDB88320;

    logic [31:0] crc_q, crc_d;
    logic [31:0] w_crc_next;
    logic [31:0] w_crc_rev;

    // Next CRC after absorbing the current byte, and the end-of-frame check
    always_comb begin
        w_crc_next = crc_q;
        for (int i = 0; i < 8; i++) begin
            if (w_crc_next[0] ^ iv_gmii_rxd[i]) begin
                w_crc_next = (w_crc_next >> 1) ^ c_CRC_POLY;
            end else begin
                w_crc_next = w_crc_next >> 1;
            end
        end
        w_crc_rev = '0;
        for (int i = 0; i < 32; i++) begin
            w_crc_rev[i] = crc_q[31-i];
        end
        w_crc_ok = (w_crc_rev == c_CRC_RESIDUE);
    end

    // CRC seeds during the preamble and absorbs every byte after the SFD
    always_comb begin
        crc_d = crc_q;
        if (state_q == c_ST_PREAMBLE) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (state_q == c_ST_DATA && i_gmii_rx_dv) begin
            crc_d = w_crc_next;
        end
    end

    // CRC register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            crc_q <= 32'hFFFF_FFFF;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign w_crc_ok = 1'b1;
`endif

    // Next-state logic: bufid prefetch, frame FSM, word packing and strobes
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        bufid_d   = bufid_q;
        ack_d     = 1'b0;
        cnt_d     = cnt_q;
        line_d    = line_q;
        word_d    = word_q;
        data_d    = data_q;
        data_wr_d = 1'b0;
        waddr_d   = waddr_q;
        desc_d    = desc_q;
        desc_wr_d = 1'b0;
        disc_d    = 1'b0;

        // A bufid is taken only while no frame is being stored, so the id
        // used for addressing never changes under an active frame.
        if (!held_q && i_pkt_bufid_wr && (state_q != c_ST_DATA)) begin
            ack_d   = 1'b1;
            held_d  = 1'b1;
            bufid_d = iv_pkt_bufid;
        end

        case (state_q)
            c_ST_IDLE: begin
                if (i_gmii_rx_dv) begin
                    state_d = c_ST_PREAMBLE;
                end
            end

            c_ST_PREAMBLE: begin
                if (!i_gmii_rx_dv) begin
                    state_d = c_ST_IDLE;
                end else if (iv_gmii_rxd == c_SFD) begin
                    if (held_q) begin
                        state_d = c_ST_DATA;
                        cnt_d   = 12'd0;
                        line_d  = 7'd0;
                    end else begin
                        // No buffer to store into: drop the whole frame
                        state_d = c_ST_DISCARD;
                        disc_d  = 1'b1;
                    end
                end
            end

            c_ST_DATA: begin
                if (i_gmii_rx_er) begin
                    disc_d  = 1'b1;
                    state_d = i_gmii_rx_dv ? c_ST_DISCARD : c_ST_IDLE;
                end else if (i_gmii_rx_dv) begin
                    if (cnt_q == c_MAX_LEN) begin
                        // Byte 2049: oversize, the pending word is not written
                        disc_d  = 1'b1;
                        state_d = c_ST_DISCARD;
                    end else begin
                        // A full word is flushed only once a further byte
                        // proves it is not the last one.
                        if ((cnt_q[3:0] == 4'd0) && (cnt_q != 12'd0)) begin
                            data_wr_d = 1'b1;
                            data_d    = {((line_q == 7'd0) ? c_FLAG_FIRST : c_FLAG_MID),
                                         4'd0, word_q};
                            waddr_d   = {bufid_q, line_q};
                            line_d    = line_q + 7'd1;
                        end
                        if (cnt_q[3:0] == 4'd0) begin
                            word_d = {iv_gmii_rxd, 120'd0};
                        end else begin
                            word_d[w_slot +: 8] = iv_gmii_rxd;
                        end
                        cnt_d = cnt_q + 12'd1;
                    end
                end else begin
                    state_d = c_ST_IDLE;
                    if ((cnt_q < c_MIN_LEN) || !w_crc_ok) begin
                        disc_d = 1'b1;
                    end else begin
                        data_wr_d = 1'b1;
                        data_d    = {c_FLAG_LAST, w_invalid, word_q};
                        waddr_d   = {bufid_q, line_q};
                        desc_d    = {cnt_q, bufid_q};
                        desc_wr_d = 1'b1;
                        held_d    = 1'b0;
                    end
                end
            end

            c_ST_DISCARD: begin
                if (!i_gmii_rx_dv) begin
                    state_d = c_ST_IDLE;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= c_ST_IDLE;
            held_q    <= 1'b0;
            bufid_q   <= 9'd0;
            ack_q     <= 1'b0;
            cnt_q     <= 12'd0;
            line_q    <= 7'd0;
            word_q    <= 128'd0;
            data_q    <= 134'd0;
            data_wr_q <= 1'b0;
            waddr_q   <= 16'd0;
            desc_q    <= 21'd0;
            desc_wr_q <= 1'b0;
            disc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            bufid_q   <= bufid_d;
            ack_q     <= ack_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            word_q    <= word_d;
            data_q    <= data_d;
            data_wr_q <= data_wr_d;
            waddr_q   <= waddr_d;
            desc_q    <= desc_d;
            desc_wr_q <= desc_wr_d;
            disc_q    <= disc_d;
        end
    end

    assign o_pkt_bufid_ack     = ack_q;
    assign ov_pkt_data         = data_q;
    assign o_pkt_data_wr       = data_wr_q;
    assign ov_pkt_waddr        = waddr_q;
    assign ov_pkt_descriptor   = desc_q;
    assign o_pkt_descriptor_wr = desc_wr_q;
    assign o_inpkt_pulse       = desc_wr_q;
    assign o_discard_pulse     = disc_q;
    assign ov_nrx_state        = state_q;

endmodule
`default_nettype wire
